// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller, ALU control and datapath.
package mc_pkg;

  localparam int OP_W_DEF = 6;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_J     = 6'h02;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  // alu_src_b select codes
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  // alu_opp codes
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // pc_source codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_opp;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state decode for the multicycle controller.
module mc_next_state
  import mc_pkg::*;
#(
  parameter int              OP_W     = OP_W_DEF,
  parameter logic [OP_W-1:0] OP_RTYPE = OP_W'(OPC_RTYPE),
  parameter logic [OP_W-1:0] OP_LW    = OP_W'(OPC_LW),
  parameter logic [OP_W-1:0] OP_SW    = OP_W'(OPC_SW),
  parameter logic [OP_W-1:0] OP_BEQ   = OP_W'(OPC_BEQ),
  parameter logic [OP_W-1:0] OP_J     = OP_W'(OPC_J)
) (
  input  state_t          state,
  input  logic [OP_W-1:0] opcode,
  output state_t          state_next
);

  // opcode is only consulted in DECODE and MEMADR
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_next = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_next = S_EXEC;
        else if (opcode == OP_BEQ)              state_next = S_BRANCH;
        else if (opcode == OP_J)                state_next = S_JUMP;
        else                                    state_next = S_FETCH;
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_next = S_MEMRD;
        else if (opcode == OP_SW) state_next = S_MEMWR;
        else                      state_next = S_FETCH;
      end
      S_MEMRD:  state_next = S_MEMWB;
      S_EXEC:   state_next = S_ALUWB;
      default:  state_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int              OP_W     = OP_W_DEF,
  parameter logic [OP_W-1:0] OP_RTYPE = OP_W'(OPC_RTYPE),
  parameter logic [OP_W-1:0] OP_LW    = OP_W'(OPC_LW),
  parameter logic [OP_W-1:0] OP_SW    = OP_W'(OPC_SW),
  parameter logic [OP_W-1:0] OP_BEQ   = OP_W'(OPC_BEQ),
  parameter logic [OP_W-1:0] OP_J     = OP_W'(OPC_J)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            zeroflag,
  output logic            pc_en,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_opp,
  output logic [1:0]      pc_source,
  output logic [3:0]      state_o
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl_q;
  logic   rst_hold;

  mc_next_state #(
    .OP_W    (OP_W),
    .OP_RTYPE(OP_RTYPE),
    .OP_LW   (OP_LW),
    .OP_SW   (OP_SW),
    .OP_BEQ  (OP_BEQ),
    .OP_J    (OP_J)
  ) u_next (
    .state     (state),
    .opcode    (opcode),
    .state_next(state_next)
  );

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_opp   = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SL2;
        c.alu_opp   = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_opp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_opp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_opp       = ALUOP_SUB;
        c.pc_source     = PCSRC_ALUOUT;
        c.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        c.pc_source = PCSRC_JUMP;
        c.pc_write  = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // State and output registers. Outputs are decoded from the state being
  // entered so they always match the state register. rst_hold keeps the
  // machine in FETCH for the first cycle after reset so that cycle presents
  // FETCH outputs instead of skipping straight to DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      ctrl_q   <= '0;
      rst_hold <= 1'b1;
    end else if (rst_hold) begin
      state    <= S_FETCH;
      ctrl_q   <= decode(S_FETCH);
      rst_hold <= 1'b0;
    end else begin
      state    <= state_next;
      ctrl_q   <= decode(state_next);
    end
  end

  // PC enable: unconditional write or taken branch, same cycle as zeroflag
  always_comb begin
    pc_en = ctrl_q.pc_write | (ctrl_q.pc_write_cond & zeroflag);
  end

  assign iord       = ctrl_q.iord;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign ir_write   = ctrl_q.ir_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_opp    = ctrl_q.alu_opp;
  assign pc_source  = ctrl_q.pc_source;
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zeroflag;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_opp, pc_source;
  logic [3:0] state_o;

  multicycle_control #(.OP_W(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zeroflag(zeroflag),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_opp(alu_opp), .pc_source(pc_source), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic [14:0] outs;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Expected outputs for a state, from the controller's published table.
  // Bit order: pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg
  //            reg_write alu_src_a alu_src_b[2] alu_opp[2] pc_source[2]
  function automatic logic [14:0] exp_outs(input int st, input logic z);
    logic pw, pwc, io, mr, mw, ir, rd, m2r, rw, sa;
    logic [1:0] sb, ao, ps;
    {pw, pwc, io, mr, mw, ir, rd, m2r, rw, sa} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      0: begin mr = 1; ir = 1; sb = 2'b01; pw = 1; end
      1: begin sb = 2'b11; end
      2: begin sa = 1; sb = 2'b10; end
      3: begin mr = 1; io = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; io = 1; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; ao = 2'b01; ps = 2'b01; pwc = 1; end
      9: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {pw | (pwc & z), io, mr, mw, ir, rd, m2r, rw, sa, sb, ao, ps};
  endfunction

  task automatic push(input int st, input logic [14:0] o);
    exp_t e;
    e.st = st; e.outs = o; e.cyc = cyc;
    q.push_back(e);
  endtask

  // Runs one instruction. Opcode is only held at its real value in DECODE
  // and MEMADR; elsewhere it is scrambled. rst_at >= 0 asserts reset during
  // that step of the path. zmode: 0 random, 1 force 1, 2 force 0.
  task automatic run_instr(input logic [5:0] op, input int zmode, input int rst_at);
    int path[5];
    int n;
    logic z;
    case (op)
      6'h23:   begin path = '{0, 1, 2, 3, 4}; n = 5; end
      6'h2B:   begin path = '{0, 1, 2, 5, 0}; n = 4; end
      6'h00:   begin path = '{0, 1, 6, 7, 0}; n = 4; end
      6'h04:   begin path = '{0, 1, 8, 0, 0}; n = 3; end
      6'h02:   begin path = '{0, 1, 9, 0, 0}; n = 3; end
      default: begin path = '{0, 1, 0, 0, 0}; n = 2; end
    endcase
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      z = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      zeroflag = z;
      opcode = (path[i] == 1 || path[i] == 2) ? op : 6'($urandom);
      push(path[i], exp_outs(path[i], z));
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        cyc++;
        zeroflag = 1'b1;
        push(0, '0);
        rst = 1'b0;
        return;
      end
    end
  endtask

  // Monitor: compares every presented cycle against the scoreboard head
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (state_o != 4'(e.st)) begin
        n_bad++;
        $display("FAIL state cyc=%0d actual=%0d required=%0d", e.cyc, state_o, e.st);
      end
      n_cmp++;
      if ({pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_opp, pc_source} !== e.outs) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d st=%0d actual=%b required=%b", e.cyc, e.st,
                 {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_opp, pc_source}, e.outs);
      end
    end
  end

  initial begin
    logic [5:0] op;
    int k;
    rst = 1'b1; opcode = 6'h3F; zeroflag = 1'b1;
    // two reset cycles with zeroflag high: pc_en must still be 0
    @(posedge clk); #1; cyc++; push(0, '0);
    @(posedge clk); #1; cyc++; push(0, '0);
    rst = 1'b0;

    run_instr(6'h23, 0, -1);   // LW
    run_instr(6'h04, 1, -1);   // BEQ taken
    run_instr(6'h04, 2, -1);   // BEQ not taken
    run_instr(6'h00, 0, -1);   // R-type
    run_instr(6'h3F, 0, -1);   // unknown
    run_instr(6'h2B, 0, -1);   // SW
    run_instr(6'h02, 0, -1);   // J
    run_instr(6'h23, 0, 3);    // reset in MEMRD
    run_instr(6'h00, 0, -1);
    run_instr(6'h2B, 0, 1);    // reset in DECODE
    run_instr(6'h02, 0, -1);

    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 5));
      case (k)
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h02;
        default: op = 6'($urandom);
      endcase
      run_instr(op, 0, ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    // leave the machine in FETCH for the final cycle to be checked
    run_instr(6'h3F, 0, -1);
    @(posedge clk); #1; cyc++; push(0, exp_outs(0, 1'b0)); zeroflag = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
